// File: rtl/ssd_score_driver_pkg.sv
// Shared constants and helpers for the score keeper / 7-segment scanner.
// Holds the active-low segment codes (abcdefg, bit 6 = a), the active-low
// anode patterns, the score saturation value and the single-cycle BCD
// increment used by the score counter.
package ssd_score_driver_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODE_D0  = 4'b1110;
  localparam logic [3:0] ANODE_D1  = 4'b1101;
  localparam logic [3:0] ANODE_D2  = 4'b1011;
  localparam logic [3:0] ANODE_D3  = 4'b0111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  localparam logic [15:0] SCORE_MAX = 16'h9999;

  // Full four-digit ripple in one evaluation; digits never leave 0..9.
  function automatic logic [15:0] bcdInc(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (value[i*4 +: 4] == 4'd9) begin
          result[i*4 +: 4] = 4'd0;
        end else begin
          result[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ssd_score_driver_bcd_to_ssd.sv
// bcd_to_ssd: combinational BCD digit to active-low 7-segment code.
// Ports:
//   bcd   in  4  BCD digit (A-F treated as illegal and shown blank)
//   blank in  1  force all segments off
//   seg   out 7  active-low segments, [6]=a .. [0]=g
module bcd_to_ssd
  import ssd_score_driver_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/ssd_score_driver.sv
// ssd_score_driver: 4-digit BCD score counter plus 7-segment scan driver.
// Ports:
//   Clk    in  1   system clock
//   Reset  in  1   asynchronous active-low reset
//   Inc    in  1   pass indication, rising edge counted
//   Clear  in  1   synchronous score clear, wins over Inc
//   Lost   in  1   freezes the score while high
//   score  out 16  packed BCD score
//   ssdOut out 7   active-low segments, [6]=a .. [0]=g
//   anode  out 4   active-low digit enables, [0]=units .. [3]=thousands
module ssd_score_driver
  import ssd_score_driver_pkg::*;
#(
  parameter int SCAN_BITS = 18
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Inc,
  input  logic        Clear,
  input  logic        Lost,
  output logic [15:0] score,
  output logic [6:0]  ssdOut,
  output logic [3:0]  anode
);

  logic                 incQ;
  logic                 incRise;
  logic [SCAN_BITS-1:0] scanCnt;
  logic [1:0]           sel;
  logic [3:0]           digit;
  logic                 blank;
  logic [3:0]           anodeNext;
  logic [6:0]           segNext;

  assign incRise = Inc & ~incQ;
  assign sel     = scanCnt[SCAN_BITS-1:SCAN_BITS-2];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      incQ  <= 1'b0;
      score <= 16'h0000;
    end else begin
      incQ <= Inc;
      if (Clear) begin
        score <= 16'h0000;
      end else if (incRise && !Lost && (score != SCORE_MAX)) begin
        score <= bcdInc(score);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      scanCnt <= '0;
    end else begin
      scanCnt <= scanCnt + {{(SCAN_BITS-1){1'b0}}, 1'b1};
    end
  end

  // Leading-zero blanking: a digit is blank only if it and every digit
  // above it are zero; the units digit always shows.
  always_comb begin
    digit     = score[3:0];
    blank     = 1'b0;
    anodeNext = ANODE_D0;
    case (sel)
      2'd0: begin
        digit     = score[3:0];
        blank     = 1'b0;
        anodeNext = ANODE_D0;
      end
      2'd1: begin
        digit     = score[7:4];
        blank     = (score[15:4] == 12'h000);
        anodeNext = ANODE_D1;
      end
      2'd2: begin
        digit     = score[11:8];
        blank     = (score[15:8] == 8'h00);
        anodeNext = ANODE_D2;
      end
      default: begin
        digit     = score[15:12];
        blank     = (score[15:12] == 4'h0);
        anodeNext = ANODE_D3;
      end
    endcase
  end

  bcd_to_ssd uSeg (
    .bcd   (digit),
    .blank (blank),
    .seg   (segNext)
  );

  // Anode and segments are registered together so they always agree.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      anode  <= ANODE_OFF;
      ssdOut <= SEG_BLANK;
    end else begin
      anode  <= anodeNext;
      ssdOut <= segNext;
    end
  end

endmodule

// File: tb/tb_ssd_score_driver.sv
module tb_ssd_score_driver;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Inc = 1'b0;
  logic        Clear = 1'b0;
  logic        Lost = 1'b0;
  logic [15:0] score;
  logic [6:0]  ssdOut;
  logic [3:0]  anode;

  int nChecks = 0;
  int nPass   = 0;
  int cyc;

  logic [6:0] segTab [10];

  typedef struct {
    logic        inc;
    logic        clear;
    logic        lost;
    logic [15:0] expScore;
  } vec_t;

  vec_t vecs [12];

  ssd_score_driver #(.SCAN_BITS(4)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Inc    (Inc),
    .Clear  (Clear),
    .Lost   (Lost),
    .score  (score),
    .ssdOut (ssdOut),
    .anode  (anode)
  );

  always #5 Clk = ~Clk;

  // Edges seen since reset release; the scan slot follows from this.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      Inc = 1'b1; tick();
      Inc = 1'b0; tick();
    end
  endtask

  // One full scan of 16 clocks against a hand-built display of expScore.
  task automatic checkScan(input logic [15:0] expScore);
    int idx;
    logic [3:0] d;
    logic       blk;
    logic [6:0] expSeg;
    logic [3:0] expAn;
    for (int i = 0; i < 16; i++) begin
      tick();
      idx = ((cyc - 1) >> 2) & 3;
      d   = expScore[idx*4 +: 4];
      case (idx)
        1:       blk = (expScore[15:4] == 12'h0);
        2:       blk = (expScore[15:8] == 8'h0);
        3:       blk = (expScore[15:12] == 4'h0);
        default: blk = 1'b0;
      endcase
      expSeg = blk ? 7'b1111111 : segTab[d];
      expAn  = 4'b1111;
      expAn[idx] = 1'b0;
      check($sformatf("scan %h slot %0d", expScore, idx), {anode, ssdOut}, {expAn, expSeg});
    end
  endtask

  initial begin
    segTab[0] = 7'b0000001; segTab[1] = 7'b1001111; segTab[2] = 7'b0010010;
    segTab[3] = 7'b0000110; segTab[4] = 7'b1001100; segTab[5] = 7'b0100100;
    segTab[6] = 7'b0100000; segTab[7] = 7'b0001111; segTab[8] = 7'b0000000;
    segTab[9] = 7'b0000100;

    //           inc   clear lost  score
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0001};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0001};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0001};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h0001};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0001};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0002};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0002};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0001};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0000};

    // Reset state
    #12;
    check("reset anode", anode, 4'b1111);
    check("reset ssdOut", ssdOut, 7'b1111111);
    check("reset score", score, 16'h0000);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    check("first display", {anode, ssdOut}, {4'b1110, 7'b0000001});
    checkScan(16'h0000);

    // Table-driven priority / edge vectors
    for (int i = 0; i < 12; i++) begin
      Inc = vecs[i].inc; Clear = vecs[i].clear; Lost = vecs[i].lost;
      tick();
      check($sformatf("vec %0d score", i), score, vecs[i].expScore);
    end
    Inc = 1'b0; Clear = 1'b0; Lost = 1'b0;
    tick();

    // Level hold counts once
    Inc = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    Inc = 1'b0;
    tick();
    check("level hold", score, 16'h0001);
    Clear = 1'b1; tick(); Clear = 1'b0;

    // Carry chain
    pulse(99);
    check("preload 0099", score, 16'h0099);
    checkScan(16'h0099);
    pulse(1);
    check("carry 0100", score, 16'h0100);
    checkScan(16'h0100);

    // Lost freeze
    Lost = 1'b1;
    pulse(5);
    check("lost freeze", score, 16'h0100);
    Lost = 1'b0;
    pulse(1);
    check("after lost", score, 16'h0101);

    // Saturation
    pulse(16'd9898);
    check("reach 9999", score, 16'h9999);
    pulse(1);
    check("saturate", score, 16'h9999);
    checkScan(16'h9999);

    // Clear with Inc rise in the same cycle
    Inc = 1'b1; Clear = 1'b1; tick();
    Clear = 1'b0; tick();
    Inc = 1'b0; tick();
    check("clear beats inc", score, 16'h0000);

    // Async reset mid-scan
    pulse(42);
    check("preload 0042", score, 16'h0042);
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("async score", score, 16'h0000);
    check("async anode", anode, 4'b1111);
    check("async ssdOut", ssdOut, 7'b1111111);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    check("post reset display", {anode, ssdOut}, {4'b1110, 7'b0000001});

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
